// File: rtl/tt_sweep_capture.sv
// tt_sweep_capture: sweeps every input pattern onto pi, samples po after a
// settle delay, and compares the captured truth table against an expected one.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request a sweep (accepted only when idle)
//   expected        reference truth table, latched when start is accepted
//   pi / po         pattern driven to the logic under test / its response
//   busy, done      sweep in progress / one-cycle completion pulse
//   tt              captured truth table
//   mismatch        at least one pattern differed from expected
//   fail_count      number of differing patterns
//   first_fail_idx  lowest differing pattern index (0 if none)
module tt_sweep_capture #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1,
    localparam int TT_W  = 2 ** N_IN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [TT_W-1:0]   expected,
    output logic [N_IN-1:0]   pi,
    input  logic              po,
    output logic              busy,
    output logic              done,
    output logic [TT_W-1:0]   tt,
    output logic              mismatch,
    output logic [N_IN:0]     fail_count,
    output logic [N_IN-1:0]   first_fail_idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [3:0]      SET_C   = 4'(SETTLE);
    localparam logic [N_IN-1:0] IDX_MAX = {N_IN{1'b1}};

    state_t            state_q, state_d;
    logic [TT_W-1:0]   exp_q, exp_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [N_IN-1:0]   pi_q, pi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [TT_W-1:0]   tt_q, tt_d;
    logic              mism_q, mism_d;
    logic [N_IN:0]     fc_q, fc_d;
    logic [N_IN-1:0]   ffi_q, ffi_d;

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pi_d    = pi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tt_d    = tt_q;
        mism_d  = mism_q;
        fc_d    = fc_q;
        ffi_d   = ffi_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    exp_d   = expected;
                    idx_d   = '0;
                    pi_d    = '0;
                    cnt_d   = '0;
                    tt_d    = '0;
                    mism_d  = 1'b0;
                    fc_d    = '0;
                    ffi_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // cnt counts 0..SETTLE; the edge where it equals SETTLE samples po
                if (cnt_q != SET_C) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    tt_d[idx_q] = po;
                    if (po != exp_q[idx_q]) begin
                        mism_d = 1'b1;
                        fc_d   = fc_q + 1'b1;
                        if (fc_q == '0) begin
                            ffi_d = idx_q;
                        end
                    end
                    if (idx_q == IDX_MAX) begin
                        // done is visible in FIN while busy has already dropped
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        pi_d  = idx_q + 1'b1;
                        cnt_d = '0;
                    end
                end
            end
            S_FIN: begin
                pi_d    = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            exp_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            pi_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tt_q    <= '0;
            mism_q  <= 1'b0;
            fc_q    <= '0;
            ffi_q   <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pi_q    <= pi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tt_q    <= tt_d;
            mism_q  <= mism_d;
            fc_q    <= fc_d;
            ffi_q   <= ffi_d;
        end
    end

    assign pi             = pi_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign tt             = tt_q;
    assign mismatch       = mism_q;
    assign fail_count     = fc_q;
    assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: two instances (SETTLE=0 and SETTLE=3), each
// driving a lookup-table model of the logic under test.
module tb_tt_sweep_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_v [2];
    logic [15:0] exp_v   [2];
    logic [15:0] lut_v   [2];
    logic [3:0]  pi_v    [2];
    logic        po_v    [2];
    logic        busy_v  [2];
    logic        done_v  [2];
    logic [15:0] tt_v    [2];
    logic        mism_v  [2];
    logic [4:0]  fc_v    [2];
    logic [3:0]  ffi_v   [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign po_v[0] = lut_v[0][pi_v[0]];
    assign po_v[1] = lut_v[1][pi_v[1]];

    tt_sweep_capture #(.N_IN(4), .SETTLE(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .expected(exp_v[0]),
        .pi(pi_v[0]), .po(po_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .tt(tt_v[0]), .mismatch(mism_v[0]), .fail_count(fc_v[0]),
        .first_fail_idx(ffi_v[0])
    );

    tt_sweep_capture #(.N_IN(4), .SETTLE(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .expected(exp_v[1]),
        .pi(pi_v[1]), .po(po_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .tt(tt_v[1]), .mismatch(mism_v[1]), .fail_count(fc_v[1]),
        .first_fail_idx(ffi_v[1])
    );

    typedef struct {
        int          inst;
        logic [15:0] lut;
        logic [15:0] ex;
        logic [15:0] tt;
        logic        m;
        logic [4:0]  fc;
        logic [3:0]  ffi;
    } vec_t;

    vec_t tbl [6];

    function automatic int settle_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: truth table is the lut itself; failures are the bits where
    // lut and expected differ.
    task automatic model(input logic [15:0] lut, input logic [15:0] ex,
                         output logic m, output logic [4:0] fc,
                         output logic [3:0] ffi);
        fc  = 0;
        ffi = 0;
        for (int k = 0; k < 16; k++) begin
            if (lut[k] != ex[k]) begin
                if (fc == 0) ffi = 4'(k);
                fc = fc + 5'd1;
            end
        end
        m = (lut != ex);
    endtask

    task automatic sweep(input string nm, input int i,
                         input logic [15:0] lut, input logic [15:0] ex,
                         input logic [15:0] e_tt, input logic e_m,
                         input logic [4:0] e_fc, input logic [3:0] e_ffi);
        int s;
        int n;
        int bad;
        bit got;
        s = settle_of(i);
        lut_v[i] = lut;
        @(negedge clk);
        exp_v[i] = ex;
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
        exp_v[i] = 16'($urandom);
        chk({nm, " busy_after_accept"}, 32'(busy_v[i]), 1);
        n = 0;
        bad = 0;
        got = 0;
        while (!got && n < 2000) begin
            if (n < 16 * (s + 1) && pi_v[i] != 4'(n / (s + 1))) bad++;
            if (n > 0 && !busy_v[i]) bad++;
            @(negedge clk);
            n++;
            if (done_v[i]) got = 1;
        end
        chk({nm, " done_latency"}, 32'(n), 32'(16 * (s + 1)));
        chk({nm, " pi_busy_timing"}, 32'(bad), 0);
        chk({nm, " busy_at_done"}, 32'(busy_v[i]), 0);
        chk({nm, " tt"}, 32'(tt_v[i]), 32'(e_tt));
        chk({nm, " mismatch"}, 32'(mism_v[i]), 32'(e_m));
        chk({nm, " fail_count"}, 32'(fc_v[i]), 32'(e_fc));
        chk({nm, " first_fail_idx"}, 32'(ffi_v[i]), 32'(e_ffi));
        @(negedge clk);
        chk({nm, " done_one_cycle"}, 32'(done_v[i]), 0);
        chk({nm, " pi_after"}, 32'(pi_v[i]), 0);
        exp_v[i] = 16'($urandom);
        repeat (3) @(negedge clk);
        chk({nm, " tt_hold"}, 32'(tt_v[i]), 32'(e_tt));
        chk({nm, " fc_hold"}, 32'(fc_v[i]), 32'(e_fc));
    endtask

    initial begin
        logic        rm;
        logic [4:0]  rfc;
        logic [3:0]  rffi;
        logic [15:0] rl;
        logic [15:0] re;
        int          ri;
        int          n;
        int          dones;
        int          dn;

        tbl[0] = '{0, 16'h8888, 16'h8888, 16'h8888, 1'b0, 5'd0,  4'd0};
        tbl[1] = '{0, 16'h8888, 16'h8889, 16'h8888, 1'b1, 5'd1,  4'd0};
        tbl[2] = '{1, 16'h00FF, 16'h00FF, 16'h00FF, 1'b0, 5'd0,  4'd0};
        tbl[3] = '{0, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1, 5'd16, 4'd0};
        tbl[4] = '{0, 16'h00FF, 16'h0F0F, 16'h00FF, 1'b1, 5'd8,  4'd4};
        tbl[5] = '{1, 16'h8888, 16'h8000, 16'h8888, 1'b1, 5'd3,  4'd3};

        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            exp_v[i] = 16'hA5A5;
            lut_v[i] = 16'hFFFF;
        end

        repeat (3) @(negedge clk);
        chk("reset pi", 32'(pi_v[0]), 0);
        chk("reset busy", 32'(busy_v[0]), 0);
        chk("reset done", 32'(done_v[0]), 0);
        chk("reset tt", 32'(tt_v[0]), 0);
        chk("reset mismatch", 32'(mism_v[0]), 0);
        chk("reset fail_count", 32'(fc_v[0]), 0);
        chk("reset first_fail_idx", 32'(ffi_v[0]), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle no start tt", 32'(tt_v[0]), 0);

        for (int v = 0; v < 6; v++) begin
            sweep($sformatf("vec%0d", v), tbl[v].inst, tbl[v].lut, tbl[v].ex,
                  tbl[v].tt, tbl[v].m, tbl[v].fc, tbl[v].ffi);
        end

        // start pulses and expected changes during a sweep are ignored
        lut_v[0] = 16'h8888;
        @(negedge clk);
        exp_v[0] = 16'h8888;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        n = 0;
        dones = 0;
        dn = -1;
        while (n < 40) begin
            start_v[0] = (n == 3 || n == 9);
            if (n == 5) exp_v[0] = 16'h0000;
            @(negedge clk);
            n++;
            if (done_v[0]) begin
                dones++;
                if (dn < 0) dn = n;
            end
        end
        start_v[0] = 1'b0;
        chk("busy_start done_count", 32'(dones), 1);
        chk("busy_start done_cycle", 32'(dn), 16);
        chk("busy_start tt", 32'(tt_v[0]), 32'h8888);
        chk("busy_start mismatch", 32'(mism_v[0]), 0);

        // reset in the middle of a sweep
        @(negedge clk);
        exp_v[0] = 16'h0000;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset pi", 32'(pi_v[0]), 0);
        chk("midreset busy", 32'(busy_v[0]), 0);
        chk("midreset tt", 32'(tt_v[0]), 0);
        dones = 0;
        repeat (2) begin
            @(negedge clk);
            if (done_v[0]) dones++;
        end
        chk("midreset no_done", 32'(dones), 0);
        chk("midreset fail_count", 32'(fc_v[0]), 0);
        rst_n = 1'b1;
        sweep("after_reset", 0, 16'h8888, 16'h8888, 16'h8888, 1'b0, 5'd0, 4'd0);

        // random tables against the reference model
        for (int r = 0; r < 16; r++) begin
            rl = 16'($urandom);
            re = (r % 4 == 0) ? rl : 16'($urandom);
            ri = int'($urandom_range(0, 1));
            model(rl, re, rm, rfc, rffi);
            sweep($sformatf("rand%0d", r), ri, rl, re, rl, rm, rfc, rffi);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
